// File: rtl/snoopsplit_n_pkg.sv
// Shared types and helpers for the N-way snooper splitter: FSM state encoding,
// width defaults and a wrapping way-index adder used by the arbiter.
package snoop_pkg;

  localparam int DEFAULT_DATA_WIDTH = 64;
  localparam int DEFAULT_ADDR_WIDTH = 10;

  typedef enum logic {
    SELECT = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // (base + off) modulo n_ways, valid for base < n_ways and off < n_ways.
  function automatic int wrap_way(input int base, input int off, input int n_ways);
    int sum;
    sum = base + off;
    if (sum >= n_ways) sum = sum - n_ways;
    return sum;
  endfunction

endpackage

// File: rtl/snoopsplit_n_if.sv
// Bundle of the upstream packet-mem write port, the N fanned-out ways and the
// commit/drop reporting signals of snoopsplit_n.
interface snoopsplit_n_if
  import snoop_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int N_WAYS     = 4,
  parameter int SEL_WIDTH  = $clog2(N_WAYS)
);

  logic [ADDR_WIDTH-1:0]        wr_addr;
  logic [DATA_WIDTH-1:0]        wr_data;
  logic                         mem_ready;
  logic                         wr_en;
  logic                         done;
  logic [N_WAYS*ADDR_WIDTH-1:0] wr_addr_out;
  logic [N_WAYS*DATA_WIDTH-1:0] wr_data_out;
  logic [N_WAYS-1:0]            mem_ready_in;
  logic [N_WAYS-1:0]            wr_en_out;
  logic [N_WAYS-1:0]            done_out;
  logic [SEL_WIDTH-1:0]         choice;
  logic                         commit_valid;
  logic [SEL_WIDTH-1:0]         commit_way;
  logic                         drop;

  modport slave (
    input  wr_addr, wr_data, wr_en, done, mem_ready_in,
    output mem_ready, wr_addr_out, wr_data_out, wr_en_out, done_out,
           choice, commit_valid, commit_way, drop
  );

  modport master (
    output wr_addr, wr_data, wr_en, done, mem_ready_in,
    input  mem_ready, wr_addr_out, wr_data_out, wr_en_out, done_out,
           choice, commit_valid, commit_way, drop
  );

endinterface

// File: rtl/snoopsplit_n_arb.sv
// Combinational way arbiter: first ready way searching upward from start with
// wrap. Tying start to 0 gives fixed lowest-index priority.
module snoopsplit_arb
  import snoop_pkg::*;
#(
  parameter int N_WAYS    = 4,
  parameter int SEL_WIDTH = $clog2(N_WAYS)
) (
  input  logic [N_WAYS-1:0]    ready,
  input  logic [SEL_WIDTH-1:0] start,
  output logic [SEL_WIDTH-1:0] grant,
  output logic                 any_ready
);

  logic [SEL_WIDTH-1:0] idx;

  // NOTE: every output of a combinational block is given a default before any
  // conditional assignment so no path leaves it unassigned (no latch).
  always_comb begin
    grant     = '0;
    idx       = '0;
    any_ready = |ready;
    // Walk from the farthest offset down so the nearest ready way wins last.
    for (int i = N_WAYS - 1; i >= 0; i--) begin
      idx = SEL_WIDTH'(wrap_way(int'(start), i, N_WAYS));
      if (ready[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/snoopsplit_n.sv
// N-way snooper splitter: locks one ready way per packet and reports each
// committed packet's way in order. Define SNOOPSPLIT_RR_EN for round-robin arbitration.
module snoopsplit_n
  import snoop_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int N_WAYS     = 4,
  parameter int SEL_WIDTH  = $clog2(N_WAYS)
) (
  input logic           clk,
  input logic           rst_n,
  snoopsplit_n_if.slave bus
);

  state_t               state, state_next;
  logic [SEL_WIDTH-1:0] locked_way, locked_next;
  logic [SEL_WIDTH-1:0] rr_ptr;
  logic [SEL_WIDTH-1:0] grant;
  logic [SEL_WIDTH-1:0] choice;
  logic                 any_ready;
  logic                 fwd;
  logic                 commit_set;
  logic                 drop_set;
  logic                 commit_valid_q;
  logic [SEL_WIDTH-1:0] commit_way_q;
  logic                 drop_q;
  logic [N_WAYS-1:0]    way_mask;

  snoopsplit_arb #(
    .N_WAYS   (N_WAYS),
    .SEL_WIDTH(SEL_WIDTH)
  ) u_arb (
    .ready    (bus.mem_ready_in),
    .start    (rr_ptr),
    .grant    (grant),
    .any_ready(any_ready)
  );

  always_comb begin
    state_next    = state;
    locked_next   = locked_way;
    choice        = locked_way;
    bus.mem_ready = 1'b0;
    fwd           = 1'b0;
    commit_set    = 1'b0;
    drop_set      = 1'b0;
    unique case (state)
      SELECT: begin
        bus.mem_ready = any_ready;
        fwd           = any_ready;
        if (any_ready) choice = grant;
        if (bus.wr_en || bus.done) begin
          if (!any_ready) begin
            drop_set = 1'b1;
          end else if (bus.done) begin
            commit_set = 1'b1;
          end else begin
            locked_next = grant;
            state_next  = LOCKED;
          end
        end
      end
      LOCKED: begin
        // Locked way keeps receiving beats even if its ready drops.
        bus.mem_ready = bus.mem_ready_in[locked_way];
        fwd           = 1'b1;
        if (bus.done) begin
          commit_set = 1'b1;
          state_next = SELECT;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= SELECT;
      locked_way     <= '0;
      commit_valid_q <= 1'b0;
      commit_way_q   <= '0;
      drop_q         <= 1'b0;
    end else begin
      state          <= state_next;
      locked_way     <= locked_next;
      commit_valid_q <= commit_set;
      drop_q         <= drop_set;
      if (commit_set) commit_way_q <= choice;
    end
  end

`ifdef SNOOPSPLIT_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (commit_set) begin
      rr_ptr <= (choice == SEL_WIDTH'(N_WAYS - 1)) ? '0 : choice + 1'b1;
    end
  end
`else
  assign rr_ptr = '0;
`endif

  assign way_mask         = fwd ? (N_WAYS'(1) << choice) : '0;
  assign bus.wr_en_out    = bus.wr_en ? way_mask : '0;
  assign bus.done_out     = bus.done  ? way_mask : '0;
  assign bus.wr_addr_out  = {N_WAYS{bus.wr_addr}};
  assign bus.wr_data_out  = {N_WAYS{bus.wr_data}};
  assign bus.choice       = choice;
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_way   = commit_way_q;
  assign bus.drop         = drop_q;

endmodule

// File: tb/tb_snoopsplit_n.sv
// Directed bench for snoopsplit_n: a 4-way instance for packets, locking, drop,
// single-beat and reset, and a 3-way instance for pointer wrap.
module tb_snoopsplit_n;
  import snoop_pkg::*;

  localparam int DW = 64;
  localparam int AW = 10;
`ifdef SNOOPSPLIT_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  snoopsplit_n_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_WAYS(4)) bus4 ();
  snoopsplit_n_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_WAYS(3)) bus3 ();

  snoopsplit_n #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_WAYS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  snoopsplit_n #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_WAYS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  int tests  = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic we, input logic dn, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    bus4.wr_en   = we;
    bus4.done    = dn;
    bus4.wr_addr = a;
    bus4.wr_data = d;
  endtask

  task automatic drive3(input logic we, input logic dn);
    bus3.wr_en = we;
    bus3.done  = dn;
  endtask

  initial begin
    int exp_way;
    logic [DW-1:0] d;

    rst_n = 1'b0;
    drive4(1'b0, 1'b0, '0, '0);
    bus4.mem_ready_in = 4'hF;
    drive3(1'b0, 1'b0);
    bus3.wr_addr = '0;
    bus3.wr_data = '0;
    bus3.mem_ready_in = 3'b000;

    #2;
    check("rst_commit_valid", bus4.commit_valid, 1'b0);
    check("rst_commit_way",   bus4.commit_way,   2'd0);
    check("rst_drop",         bus4.drop,         1'b0);
    check("rst_choice",       bus4.choice,       2'd0);
    check("rst_wr_en_out",    bus4.wr_en_out,    4'b0000);
    check("rst_mem_ready",    bus4.mem_ready,    1'b1);
    #10 rst_n = 1'b1;
    cycle();

    // Three back-to-back 8-beat packets with every way ready.
    for (int p = 0; p < 3; p++) begin
      exp_way = RR ? p : 0;
      for (int b = 0; b < 8; b++) begin
        d = 64'hA5A5_0000_0000_0000 | (64'(p) << 8) | 64'(b);
        drive4(1'b1, b == 7, AW'(b), d);
        #1;
        check("pkt_wr_en_out", bus4.wr_en_out, 4'b0001 << exp_way);
        if (b == 0) begin
          check("pkt_data_repl", bus4.wr_data_out, {4{d}});
          check("pkt_addr_repl", bus4.wr_addr_out, {4{AW'(b)}});
        end
        if (b == 7) check("pkt_done_out", bus4.done_out, 4'b0001 << exp_way);
        cycle();
      end
      check("pkt_commit_valid", bus4.commit_valid, 1'b1);
      check("pkt_commit_way",   bus4.commit_way,   exp_way);
    end
    drive4(1'b0, 1'b0, '0, '0);
    cycle();
    check("pkt_commit_pulse", bus4.commit_valid, 1'b0);

    // Lock way 2, then its ready drops while other ways become ready.
    bus4.mem_ready_in = 4'b0100;
    drive4(1'b1, 1'b0, 10'h10, 64'h1);
    #1;
    check("lock_first_beat", bus4.wr_en_out, 4'b0100);
    cycle();
    bus4.mem_ready_in = 4'b1011;
    drive4(1'b1, 1'b0, 10'h11, 64'h2);
    #1;
    check("lock_mem_ready", bus4.mem_ready, 1'b0);
    check("lock_choice",    bus4.choice,    2'd2);
    check("lock_wr_en_out", bus4.wr_en_out, 4'b0100);
    cycle();
    drive4(1'b1, 1'b1, 10'h12, 64'h3);
    #1;
    check("lock_done_out", bus4.done_out, 4'b0100);
    cycle();
    drive4(1'b0, 1'b0, '0, '0);
    check("lock_commit_valid", bus4.commit_valid, 1'b1);
    check("lock_commit_way",   bus4.commit_way,   2'd2);

    // No way ready: write is dropped and FSM stays in SELECT.
    bus4.mem_ready_in = 4'b0000;
    drive4(1'b1, 1'b0, 10'h20, 64'h4);
    #1;
    check("drop_wr_en_out", bus4.wr_en_out, 4'b0000);
    check("drop_mem_ready", bus4.mem_ready, 1'b0);
    check("drop_choice",    bus4.choice,    2'd2);
    cycle();
    drive4(1'b0, 1'b0, '0, '0);
    check("drop_pulse",        bus4.drop,         1'b1);
    check("drop_no_commit",    bus4.commit_valid, 1'b0);
    cycle();
    check("drop_pulse_end", bus4.drop, 1'b0);
    bus4.mem_ready_in = 4'b1010;
    #1;
    check("drop_still_select", bus4.mem_ready, 1'b1);

    // Single-beat packet with ways 1 and 3 ready.
    exp_way = RR ? 3 : 1;
    drive4(1'b1, 1'b1, 10'h30, 64'h5);
    #1;
    check("single_wr_en_out", bus4.wr_en_out, 4'b0001 << exp_way);
    check("single_done_out",  bus4.done_out,  4'b0001 << exp_way);
    cycle();
    drive4(1'b0, 1'b0, '0, '0);
    check("single_commit_valid", bus4.commit_valid, 1'b1);
    check("single_commit_way",   bus4.commit_way,   exp_way);
    bus4.mem_ready_in = 4'b0001;
    #1;
    check("single_stays_select", bus4.choice, 2'd0);

    // Commit on way 0 (moves the round-robin pointer), then reset mid-packet on way 3.
    drive4(1'b1, 1'b1, 10'h40, 64'h6);
    cycle();
    bus4.mem_ready_in = 4'b1000;
    drive4(1'b1, 1'b0, 10'h41, 64'h7);
    cycle();
    drive4(1'b1, 1'b0, 10'h42, 64'h8);
    #1;
    check("rstmid_wr_en_out", bus4.wr_en_out, 4'b1000);
    #2;
    rst_n = 1'b0;
    drive4(1'b0, 1'b0, '0, '0);
    bus4.mem_ready_in = 4'b0000;
    #1;
    check("rstmid_outputs",      bus4.wr_en_out,    4'b0000);
    check("rstmid_choice",       bus4.choice,       2'd0);
    check("rstmid_commit_valid", bus4.commit_valid, 1'b0);
    check("rstmid_mem_ready",    bus4.mem_ready,    1'b0);
    cycle();
    cycle();
    rst_n = 1'b1;
    bus4.mem_ready_in = 4'hF;
    #1;
    check("rstmid_choice_after", bus4.choice, 2'd0);
    cycle();
    check("rstmid_no_commit", bus4.commit_valid, 1'b0);

    // 3-way instance: pointer reaches 2, then wraps.
    bus3.mem_ready_in = 3'b010;
    drive3(1'b1, 1'b1);
    #1;
    check("w3_choice_1", bus3.choice, 2'd1);
    cycle();
    drive3(1'b0, 1'b0);
    check("w3_commit_way_1", bus3.commit_way, 2'd1);
    bus3.mem_ready_in = 3'b001;
    #1;
    check("w3_choice_wrap", bus3.choice,    2'd0);
    check("w3_mem_ready",   bus3.mem_ready, 1'b1);
    drive3(1'b1, 1'b1);
    #1;
    check("w3_wr_en_out", bus3.wr_en_out, 3'b001);
    cycle();
    drive3(1'b0, 1'b0);
    check("w3_commit_way_0", bus3.commit_way, 2'd0);
    bus3.mem_ready_in = 3'b111;
    #1;
    check("w3_choice_after0", bus3.choice, RR ? 2'd1 : 2'd0);
    bus3.mem_ready_in = 3'b100;
    drive3(1'b1, 1'b1);
    cycle();
    drive3(1'b0, 1'b0);
    check("w3_commit_way_2", bus3.commit_way, 2'd2);
    bus3.mem_ready_in = 3'b111;
    #1;
    check("w3_choice_after2", bus3.choice, 2'd0);
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
